// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding and sizing constants for seq_divider
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_sub_stage.sv
// rtl/div_sub_stage.sv - W-bit subtractor returning difference and borrow
module div_sub_stage #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring multi-cycle divider, one quotient bit per clock
// SEQ_DIVIDER_SIGNED_EN enables two's-complement operation via signed_op.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH-1:0] dvnd_q, dvnd_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   sub_a, sub_b, sub_diff;
    logic             sub_borrow;
    logic             sub_msb_unused;
    logic [WIDTH-1:0] dividend_mag, divisor_mag;
    logic [WIDTH-1:0] fix_quo, fix_rem;

    // CALC: trial subtract of shifted partial remainder; FIX: 0 - quotient
    always_comb begin
        if (state_q == CALC) begin
            sub_a = {rem_q, quo_q[WIDTH-1]};
            sub_b = {1'b0, dvsr_q};
        end else begin
            sub_a = '0;
            sub_b = {1'b0, quo_q};
        end
    end

    div_sub_stage #(.W(WIDTH + 1)) u_sub (
        .a      (sub_a),
        .b      (sub_b),
        .diff   (sub_diff),
        .borrow (sub_borrow)
    );

    assign sub_msb_unused = sub_diff[WIDTH];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic sgn_a, sgn_b;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign sgn_a        = signed_op & dividend[WIDTH-1];
    assign sgn_b        = signed_op & divisor[WIDTH-1];
    assign dividend_mag = sgn_a ? (WIDTH'(0) - dividend) : dividend;
    assign divisor_mag  = sgn_b ? (WIDTH'(0) - divisor) : divisor;

    always_comb begin
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (state_q == IDLE && start) begin
            neg_quo_d = sgn_a ^ sgn_b;
            neg_rem_d = sgn_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign fix_quo = neg_quo_q ? sub_diff[WIDTH-1:0] : quo_q;
    assign fix_rem = neg_rem_q ? (WIDTH'(0) - rem_q) : rem_q;
`else
    logic signed_op_unused;

    assign signed_op_unused = signed_op;
    assign dividend_mag     = dividend;
    assign divisor_mag      = divisor;
    assign fix_quo          = quo_q;
    assign fix_rem          = rem_q;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        dvnd_d      = dvnd_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    quo_d   = dividend_mag;
                    dvsr_d  = divisor_mag;
                    dvnd_d  = dividend;
                    zero_d  = (divisor == '0);
                    rem_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = (divisor == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = sub_borrow ? sub_a[WIDTH-1:0] : sub_diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~sub_borrow};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = dvnd_q;
                    dbz_d       = 1'b1;
                end else begin
                    quotient_d  = fix_quo;
                    remainder_d = fix_rem;
                    dbz_d       = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            dvnd_q      <= '0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            dvnd_q      <= dvnd_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider (honours SEQ_DIVIDER_SIGNED_EN)
module tb_seq_divider;

    localparam int W = 32;
`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    wire          busy;
    wire          done;
    wire  [W-1:0] quotient;
    wire  [W-1:0] remainder;
    wire          div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic         s;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain integer arithmetic, truncating division.
    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic z);
        longint sa;
        longint sb;
        z = (b == 0);
        if (z) begin
            q = '1;
            r = a;
        end else if (s && SIGNED_BUILD) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        signed_op = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        cyc       = 0;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit early;
        early = 1'b0;
        lat   = -1;
        while (cyc < 200) begin
            if (busy !== 1'b1) early = 1'b1;
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        check({tag, "_busy_held"}, early, 0);
    endtask

    task automatic run_check(input string tag, input logic s, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] eq,
                             input logic [W-1:0] er, input logic ez, input int elat);
        int lat;
        launch(s, a, b);
        wait_done(tag, lat);
        check({tag, "_latency"}, lat, elat);
        check({tag, "_quotient"}, quotient, eq);
        check({tag, "_remainder"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, ez);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] mq, mr, ra, rb;
        logic         mz, rs;
        int           lat;

        vecs.push_back('{1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'd7,
                         SIGNED_BUILD ? 32'hFFFF_FFF2 : 32'h2492_4916,
                         SIGNED_BUILD ? 32'hFFFF_FFFE : 32'd2, 1'b0, 34});
        vecs.push_back('{1'b1, 32'd100, 32'hFFFF_FFF9,
                         SIGNED_BUILD ? 32'hFFFF_FFF2 : 32'd0,
                         SIGNED_BUILD ? 32'd2 : 32'd100, 1'b0, 34});
        vecs.push_back('{1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2});
        vecs.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                         SIGNED_BUILD ? 32'h8000_0000 : 32'd0,
                         SIGNED_BUILD ? 32'd0 : 32'h8000_0000, 1'b0, 34});
        vecs.push_back('{1'b1, 32'hFFFF_FFF6, 32'd3,
                         SIGNED_BUILD ? 32'hFFFF_FFFD : 32'h5555_5552,
                         SIGNED_BUILD ? 32'hFFFF_FFFF : 32'd0, 1'b0, 34});
        vecs.push_back('{1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 2});
        vecs.push_back('{1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 34});
        vecs.push_back('{1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 1'b0, 34});
        vecs.push_back('{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                         SIGNED_BUILD ? 32'd14 : 32'd0,
                         SIGNED_BUILD ? 32'hFFFF_FFFE : 32'hFFFF_FF9C, 1'b0, 34});

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        rst_n = 1'b1;

        // Directed table, issued back to back
        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b,
                      vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].lat);
        end

        // Randomised operands against the reference model
        for (int n = 0; n < 30; n++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = $urandom;
                default: rb = W'(0) - W'($urandom_range(1, 15));
            endcase
            ref_div(rs, ra, rb, mq, mr, mz);
            run_check($sformatf("rnd%0d", n), rs, ra, rb, mq, mr, mz, mz ? 2 : W + 2);
        end

        // start pulsed mid-operation must be ignored
        launch(1'b0, 32'd1000, 32'd3);
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        signed_op = 1'b1;
        dividend  = 32'd7;
        divisor   = 32'd0;
        start     = 1'b1;
        @(negedge clk);
        cyc++;
        start = 1'b0;
        wait_done("busy_start", lat);
        check("busy_start_latency", lat, 34);
        check("busy_start_quotient", quotient, 333);
        check("busy_start_remainder", remainder, 1);
        check("busy_start_dbz", div_by_zero, 0);

        // start held only during the DONE cycle must be ignored
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("done_start_idle%0d", k), busy, 0);
            @(negedge clk);
        end
        check("done_start_quotient", quotient, 333);

        // Asynchronous reset in the middle of an operation
        launch(1'b0, 32'hDEAD_BEEF, 32'h1234);
        while (cyc < 15) begin
            @(negedge clk);
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_div(1'b0, 32'hDEAD_BEEF, 32'h1234, mq, mr, mz);
        run_check("after_rst", 1'b0, 32'hDEAD_BEEF, 32'h1234, mq, mr, mz, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
